// File: rtl/polynomial_pkg.sv
// Shared defaults and coefficient types for the Horner polynomial evaluator.
package polynomial_pkg;

    localparam int DEGREE_DEF  = 2;
    localparam int COEFF_W_DEF = 16;
    localparam int X_W_DEF     = 10;
    localparam int Y_W_DEF     = 46;
    localparam int DEGREE_MAX  = 8;

    typedef logic [COEFF_W_DEF-1:0] coeff_t;
    typedef coeff_t coeff_arr_t [DEGREE_MAX+1];

endpackage

// File: rtl/polynomial_horner_stage.sv
// One Horner step: acc_out = acc_in * x + coef (mod 2^Y_W), registered with its
// own copy of x and a valid bit; everything holds while en is low.
module horner_stage #(
    parameter int COEFF_W = 16,
    parameter int X_W     = 10,
    parameter int Y_W     = 46
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               en,
    input  logic               prev_valid,
    input  logic [X_W-1:0]     prev_x,
    input  logic [Y_W-1:0]     prev_acc,
    input  logic [COEFF_W-1:0] coef,
    output logic               valid,
    output logic [X_W-1:0]     x,
    output logic [Y_W-1:0]     acc
);

    logic               valid_reg;
    logic [X_W-1:0]     x_reg;
    logic [Y_W-1:0]     acc_reg;
    logic [Y_W-1:0]     acc_next;

    // A Y_W-wide product already discards everything above 2^Y_W.
    assign acc_next = prev_acc * {{(Y_W-X_W){1'b0}}, prev_x}
                    + {{(Y_W-COEFF_W){1'b0}}, coef};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_reg <= 1'b0;
            x_reg     <= '0;
            acc_reg   <= '0;
        end else if (en) begin
            valid_reg <= prev_valid;
            x_reg     <= prev_x;
            acc_reg   <= acc_next;
        end
    end

    assign valid = valid_reg;
    assign x     = x_reg;
    assign acc   = acc_reg;

endmodule

// File: rtl/polynomial_horner.sv
// Pipelined unsigned polynomial evaluator: one Horner stage per degree, with
// valid/ready handshakes on the coefficient, operand and result ports.
module polynomial_horner
    import polynomial_pkg::*;
#(
    parameter int DEGREE  = DEGREE_DEF,
    parameter int COEFF_W = COEFF_W_DEF,
    parameter int X_W     = X_W_DEF,
    parameter int Y_W     = Y_W_DEF
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          coef_valid,
    output logic                          coef_ready,
    input  logic [(DEGREE+1)*COEFF_W-1:0] coef_data,
    input  logic                          x_valid,
    output logic                          x_ready,
    input  logic [X_W-1:0]                x_data,
    output logic                          y_valid,
    input  logic                          y_ready,
    output logic [Y_W-1:0]                y_data,
    output logic                          busy
);

    logic [COEFF_W-1:0] coef_reg  [DEGREE+1];
    logic [DEGREE-1:0]  stage_valid;
    logic [X_W-1:0]     stage_x   [DEGREE];
    logic [Y_W-1:0]     stage_acc [DEGREE];
    logic               stall;
    logic               coef_take;
    logic               x_take;

    assign stall      = y_valid & ~y_ready;
    assign busy       = |stage_valid;
    // Coefficients only change with the pipeline empty, so no operand sees a mix.
    assign coef_ready = ~busy;
    assign coef_take  = coef_valid & coef_ready & rstn;
    assign x_ready    = ~stall & ~coef_take;
    assign x_take     = x_valid & x_ready;

    assign y_valid = stage_valid[DEGREE-1];
    assign y_data  = stage_acc[DEGREE-1];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i <= DEGREE; i++) coef_reg[i] <= '0;
        end else if (coef_take) begin
            for (int i = 0; i <= DEGREE; i++) coef_reg[i] <= coef_data[i*COEFF_W +: COEFF_W];
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEGREE; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                // The leading coefficient seeds the accumulator of the first step.
                horner_stage #(
                    .COEFF_W (COEFF_W),
                    .X_W     (X_W),
                    .Y_W     (Y_W)
                ) u_stage (
                    .clk        (clk),
                    .rstn       (rstn),
                    .en         (~stall),
                    .prev_valid (x_take),
                    .prev_x     (x_data),
                    .prev_acc   ({{(Y_W-COEFF_W){1'b0}}, coef_reg[DEGREE]}),
                    .coef       (coef_reg[DEGREE-1]),
                    .valid      (stage_valid[0]),
                    .x          (stage_x[0]),
                    .acc        (stage_acc[0])
                );
            end else begin : g_next
                horner_stage #(
                    .COEFF_W (COEFF_W),
                    .X_W     (X_W),
                    .Y_W     (Y_W)
                ) u_stage (
                    .clk        (clk),
                    .rstn       (rstn),
                    .en         (~stall),
                    .prev_valid (stage_valid[gi-1]),
                    .prev_x     (stage_x[gi-1]),
                    .prev_acc   (stage_acc[gi-1]),
                    .coef       (coef_reg[DEGREE-1-gi]),
                    .valid      (stage_valid[gi]),
                    .x          (stage_x[gi]),
                    .acc        (stage_acc[gi])
                );
            end
        end
    endgenerate

endmodule

// File: doc/polynomial_horner.md
POLYNOMIAL_HORNER -- requirements
Module: polynomial_horner

Interface
REQ-001 Parameter DEGREE, default 2, meaning polynomial degree N (N+1 coefficients), legal range 1..8.
REQ-002 Parameter COEFF_W, default 16, meaning width of each unsigned coefficient.
REQ-003 Parameter X_W, default 10, meaning width of unsigned operand x.
REQ-004 Parameter Y_W, default 46, meaning width of unsigned result y.
REQ-005 clk  in  1  single clock; all state changes on its rising edge.
REQ-006 rstn  in  1  reset, asynchronous assert, active-low.
REQ-007 coef_valid  in  1  coefficient-set offer.
REQ-008 coef_ready  out  1  coefficient-set accept.
REQ-009 coef_data  in  (DEGREE+1)*COEFF_W  coefficient set, c[i] at bits [i*COEFF_W +: COEFF_W], c[0] = constant term.
REQ-010 x_valid  in  1  operand offer.
REQ-011 x_ready  out  1  operand accept.
REQ-012 x_data  in  X_W  operand x.
REQ-013 y_valid  out  1  result offer.
REQ-014 y_ready  in  1  result accept.
REQ-015 y_data  out  Y_W  result y = sum c[i]*x^i.
REQ-016 busy  out  1  high while any operand is in flight or held at the output.

Function
REQ-017 All three ports SHALL use valid/ready handshakes, with a transfer on any edge where valid and ready are both high; valid SHALL NOT depend combinationally on ready.
REQ-018 An accepted coefficient set SHALL be held in a coefficient register until the next accepted set.
REQ-019 Evaluation SHALL use Horner form in DEGREE pipeline stages: stage 0 computes c[N]*x + c[N-1]; stage k computes acc*x + c[N-1-k].
REQ-020 Each stage SHALL carry its own copy of x and a valid bit.
REQ-021 Arithmetic SHALL be unsigned, and every stage accumulator SHALL be truncated to Y_W bits, so results are modulo 2^Y_W.
REQ-022 The last stage register SHALL drive y_data and y_valid directly.
REQ-023 Latency SHALL be DEGREE cycles from x acceptance to y_valid, with throughput of one result per cycle when y_ready is held high.
REQ-024 stall = y_valid & ~y_ready; while stall is high, all stage registers SHALL hold, and y_data SHALL stay stable until accepted.
REQ-025 The pipeline SHALL advance when y_ready is high, accepting a new x and emitting the oldest result in the same cycle without a bubble.
REQ-026 x_ready SHALL equal ~stall & ~coef_take, where coef_take = coef_valid & coef_ready.
REQ-027 coef_ready SHALL be high only when busy is low, so coefficients never change under an in-flight operand.
REQ-028 If coef_valid and x_valid are both high while the pipeline is empty, the coefficient set SHALL be taken and x SHALL wait one cycle.
REQ-029 busy SHALL equal the OR of all stage valid bits.
REQ-030 Operands accepted before any coefficient load SHALL evaluate against all-zero coefficients (y = 0).

Reset
REQ-031 When rstn is low, all stage valid bits, coefficients and y_data SHALL clear to 0 immediately, without waiting for a clock edge.
REQ-032 While rstn is low: y_valid=0, busy=0, x_ready=1, coef_ready=1.
REQ-033 In-flight operands SHALL be discarded by reset mid-operation, and no stale result SHALL appear after release.
REQ-034 Operation SHALL resume on the first clock edge after rstn deasserts.

Structure
REQ-035 A shared package polynomial_pkg SHALL hold the default parameter constants and a coefficient-array typedef.
REQ-036 One sub-module, horner_stage, SHALL implement a single multiply-add with its registers and enable; it SHALL be instantiated DEGREE times by a generate loop.

Verification (DEGREE=2, COEFF_W=16, X_W=10, Y_W=46 unless stated)
REQ-037 Load c2=3,c1=5,c0=7, then x=10 with y_ready=1 -> y_valid exactly 2 cycles after acceptance, y_data=357.
REQ-038 Back-to-back x=0,1,2 -> consecutive y_data 7,15,29 on 3 consecutive cycles.
REQ-039 Hold y_ready=0 for 5 cycles mid-stream -> y_data stable, x_ready=0, no lost or duplicated results after release.
REQ-040 coef_valid raised while busy=1 -> coef_ready stays 0 until drain; a simultaneous coef_valid/x_valid on an empty pipeline -> coefficients win.
REQ-041 All coefficients 0xFFFF, x=1023 -> y_data equals the exact value modulo 2^46; and with DEGREE=4, coefficients 1,1,1,1,1 and x=2 -> y_data=31 after 4 cycles.
REQ-042 Assert rstn low with 2 operands in flight -> y_valid=0 at once, and no output appears after release until new x is accepted.
